// File: rtl/btn_debounce_amisha_pkg.sv
// Shared definitions for the two-button debouncer: state encoding and default tick width.
package btn_debounce_amisha_pkg;

  localparam int N_DEFAULT = 19;

  typedef enum logic [2:0] {
    ZERO    = 3'd0,
    WAIT1_1 = 3'd1,
    WAIT1_2 = 3'd2,
    WAIT1_3 = 3'd3,
    ONE     = 3'd4,
    WAIT0_1 = 3'd5,
    WAIT0_2 = 3'd6,
    WAIT0_3 = 3'd7
  } db_state_e;

  // The MSB of the encoding separates the "debounced high" half of the state space.
  function automatic logic level_of(input db_state_e s);
    return s[2];
  endfunction

endpackage

// File: rtl/btn_debounce_amisha_if.sv
// Button-side bundle: raw button levels in, debounced levels and edge pulses out.
interface btn_debounce_amisha_if;
  logic [1:0] btn_amisha;
  logic [1:0] db_level_amisha;
  logic [1:0] db_tick_amisha;

  modport master (
    output btn_amisha,
    input  db_level_amisha,
    input  db_tick_amisha
  );

  modport slave (
    input  btn_amisha,
    output db_level_amisha,
    output db_tick_amisha
  );
endinterface

// File: rtl/btn_debounce_amisha_fsm.sv
// Per-button debounce FSM: a level must hold across three tick boundaries before it is accepted.
module debounce_fsm_amisha
  import btn_debounce_amisha_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic sw,
  input  logic m_tick,
  output logic db_level,
  output logic db_tick
);

  db_state_e state_q, state_d;
  logic      tick_q, tick_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ZERO;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
    end
  end

  // sw is tested before m_tick everywhere, so a bounce always aborts a pending advance.
  always_comb begin
    state_d = state_q;
    tick_d  = 1'b0;
    case (state_q)
      ZERO: begin
        if (sw) state_d = WAIT1_1;
      end
      WAIT1_1: begin
        if (!sw)        state_d = ZERO;
        else if (m_tick) state_d = WAIT1_2;
      end
      WAIT1_2: begin
        if (!sw)        state_d = ZERO;
        else if (m_tick) state_d = WAIT1_3;
      end
      WAIT1_3: begin
        if (!sw) begin
          state_d = ZERO;
        end else if (m_tick) begin
          state_d = ONE;
          tick_d  = 1'b1;
        end
      end
      ONE: begin
        if (!sw) state_d = WAIT0_1;
      end
      WAIT0_1: begin
        if (sw)          state_d = ONE;
        else if (m_tick) state_d = WAIT0_2;
      end
      WAIT0_2: begin
        if (sw)          state_d = ONE;
        else if (m_tick) state_d = WAIT0_3;
      end
      WAIT0_3: begin
        if (sw)          state_d = ONE;
        else if (m_tick) state_d = ZERO;
      end
      default: state_d = ZERO;
    endcase
  end

  assign db_level = level_of(state_q);
  assign db_tick  = tick_q;

endmodule

// File: rtl/btn_debounce_amisha.sv
// Two-button debouncer: synchronizers and shared tick counter here, one FSM per button.
module btn_debounce_amisha
  import btn_debounce_amisha_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic                  clk_amisha,
  input  logic                  reset_amisha,
  btn_debounce_amisha_if.slave  bus
);

  logic [1:0]   sync1_q;
  logic [1:0]   sw_q;
  logic [N-1:0] cnt_q;
  logic         m_tick;
  logic [1:0]   level_w;
  logic [1:0]   tick_w;

  // Two-stage synchronizer; the raw buttons are asynchronous to clk_amisha.
  always_ff @(posedge clk_amisha or posedge reset_amisha) begin
    if (reset_amisha) begin
      sync1_q <= 2'b00;
      sw_q    <= 2'b00;
    end else begin
      sync1_q <= bus.btn_amisha;
      sw_q    <= sync1_q;
    end
  end

  always_ff @(posedge clk_amisha or posedge reset_amisha) begin
    if (reset_amisha) cnt_q <= '0;
    else              cnt_q <= cnt_q + 1'b1;
  end

  assign m_tick = (cnt_q == '0);

  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    debounce_fsm_amisha u_fsm (
      .clk      (clk_amisha),
      .reset    (reset_amisha),
      .sw       (sw_q[gi]),
      .m_tick   (m_tick),
      .db_level (level_w[gi]),
      .db_tick  (tick_w[gi])
    );
  end

  assign bus.db_level_amisha = level_w;
  assign bus.db_tick_amisha  = tick_w;

endmodule

// File: tb/tb_btn_debounce_amisha.sv
// Scoreboard bench for btn_debounce_amisha with a 4-clock debounce tick.
module tb_btn_debounce_amisha;

  localparam int N = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  btn_debounce_amisha_if bus_if ();

  btn_debounce_amisha #(.N(N)) dut (
    .clk_amisha   (clk),
    .reset_amisha (rst),
    .bus          (bus_if)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [1:0] mask;
    int         c0;
  } exp_t;

  exp_t sb_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive a new button level; a non-zero mask queues the debounced pulse it must produce.
  task automatic drive(input logic [1:0] v, input logic [1:0] mask_expect);
    exp_t e;
    bus_if.btn_amisha = v;
    if (mask_expect != 2'b00) begin
      e.mask = mask_expect;
      e.c0   = cyc;
      sb_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    int   lat;
    if (!rst && bus_if.db_tick_amisha != 2'b00) begin
      if (sb_q.size() == 0) begin
        check_val("spurious_tick", {30'd0, bus_if.db_tick_amisha}, 32'd0);
      end else begin
        e   = sb_q.pop_front();
        lat = cyc - e.c0;
        $display("tick %b at cycle %0d, latency %0d", bus_if.db_tick_amisha, cyc, lat);
        check_val("tick_mask", {30'd0, bus_if.db_tick_amisha}, {30'd0, e.mask});
        check_val("tick_lat_10_15", {31'd0, (lat >= 10 && lat <= 15)}, 32'd1);
        check_val("level_with_tick",
                  {30'd0, bus_if.db_level_amisha & bus_if.db_tick_amisha},
                  {30'd0, bus_if.db_tick_amisha});
      end
    end
  end

  task automatic measure_fall(input int idx, input string tag);
    int c0;
    int lat;
    c0  = cyc;
    lat = -1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus_if.db_level_amisha[idx] == 1'b0 && lat < 0) lat = cyc - c0;
    end
    $display("%s: level fell after %0d cycles", tag, lat);
    check_val(tag, {31'd0, (lat >= 10 && lat <= 15)}, 32'd1);
  endtask

  initial begin
    logic [1:0] seen;
    logic       bp [6];
    bp = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    bus_if.btn_amisha = 2'b00;
    rst = 1'b1;
    step(3);
    @(negedge clk);
    check_val("reset_level", {30'd0, bus_if.db_level_amisha}, 32'd0);
    check_val("reset_tick", {30'd0, bus_if.db_tick_amisha}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    step(5);

    // single press held 40 clocks
    drive(2'b01, 2'b01);
    step(40);
    check_val("press_level", {30'd0, bus_if.db_level_amisha}, 32'd1);
    check_val("press_queue_empty", sb_q.size(), 32'd0);

    // release: level falls, no pulse
    drive(2'b00, 2'b00);
    measure_fall(0, "release_fall_10_15");
    step(10);
    check_val("release_level", {30'd0, bus_if.db_level_amisha}, 32'd0);

    // short 5-clock glitch is rejected
    drive(2'b01, 2'b00);
    step(5);
    drive(2'b00, 2'b00);
    seen = 2'b00;
    repeat (30) begin
      @(negedge clk);
      seen = seen | bus_if.db_level_amisha | bus_if.db_tick_amisha;
    end
    $display("short pulse: outputs seen %b", seen);
    check_val("short_pulse_quiet", {30'd0, seen}, 32'd0);

    // simultaneous press on both buttons
    step(1);
    drive(2'b11, 2'b11);
    step(40);
    check_val("both_level", {30'd0, bus_if.db_level_amisha}, 32'd3);
    check_val("both_queue_empty", sb_q.size(), 32'd0);
    drive(2'b00, 2'b00);
    step(40);
    check_val("both_release_level", {30'd0, bus_if.db_level_amisha}, 32'd0);

    // reset while button 1 sits in WAIT1_2, held through release
    drive(2'b10, 2'b00);
    step(7);
    rst = 1'b1;
    @(negedge clk);
    check_val("midreset_level", {30'd0, bus_if.db_level_amisha}, 32'd0);
    check_val("midreset_tick", {30'd0, bus_if.db_tick_amisha}, 32'd0);
    step(3);
    rst = 1'b0;
    drive(2'b10, 2'b10);
    step(40);
    check_val("postreset_level", {30'd0, bus_if.db_level_amisha}, 32'd2);
    check_val("postreset_queue_empty", sb_q.size(), 32'd0);
    drive(2'b00, 2'b00);
    step(40);

    // bounce 1,0,1,1,0,1 then stable high; timed from the last rising transition
    for (int i = 0; i < 6; i++) begin
      drive({1'b0, bp[i]}, (i == 5) ? 2'b01 : 2'b00);
      step(1);
    end
    step(40);
    check_val("bounce_level", {30'd0, bus_if.db_level_amisha}, 32'd1);
    check_val("bounce_queue_empty", sb_q.size(), 32'd0);
    drive(2'b00, 2'b00);
    step(40);
    check_val("final_queue_empty", sb_q.size(), 32'd0);
    check_val("final_level", {30'd0, bus_if.db_level_amisha}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule

// File: doc/btn_debounce_amisha.md
BTN_DEBOUNCE_AMISHA -- requirements
Module: btn_debounce_amisha

Interface
REQ-001 Parameter N, default 19, is the tick-counter width; the debounce tick period is 2^N clocks (about 10.5 ms at 50 MHz).
REQ-002 clk_amisha  input  1  system clock; all state updates on its rising edge.
REQ-003 reset_amisha  input  1  reset, asynchronous and active-high.
REQ-004 btn_amisha  input  2  raw, bouncy, asynchronous push-button levels; bit 0 = go/stop, bit 1 = clear.
REQ-005 db_level_amisha  output  2  debounced button levels, one bit per button.
REQ-006 db_tick_amisha  output  2  one-clock pulse per debounced rising edge, per button; this output feeds the stopwatch button inputs.

Function
REQ-007 Each btn_amisha bit SHALL pass through a two-flip-flop synchronizer before any FSM use; sync output is sw[i].
REQ-008 One shared N-bit free-running up-counter SHALL wrap modulo 2^N; m_tick = 1 for exactly the one cycle the counter equals 0.
REQ-009 Each button SHALL own an independent FSM with states ZERO, WAIT1_1, WAIT1_2, WAIT1_3, ONE, WAIT0_1, WAIT0_2, WAIT0_3.
REQ-010 ZERO: sw=1 -> WAIT1_1; otherwise stay.
REQ-011 WAIT1_k: sw=0 -> ZERO; else m_tick=1 -> WAIT1_(k+1), or ONE from WAIT1_3; else stay.
REQ-012 ONE: sw=0 -> WAIT0_1; otherwise stay.
REQ-013 WAIT0_k: sw=1 -> ONE; else m_tick=1 -> WAIT0_(k+1), or ZERO from WAIT0_3; else stay.
REQ-014 When sw and m_tick are both 1 in the same cycle, sw checks SHALL take priority (a bounce aborts before tick advance).
REQ-015 db_level[i] SHALL be 1 in ONE and WAIT0_1..3 and 0 in all other states (Moore).
REQ-016 db_tick[i] SHALL be 1 for exactly the one cycle after the WAIT1_3 -> ONE transition, i.e. a registered pulse aligned with db_level rising; it SHALL never assert on falling edges.
REQ-017 Rising-edge acceptance latency SHALL be between 2*2^N+2 and 3*2^N+3 clocks after a stable high input; falling-edge latency follows the same bounds.
REQ-018 A high pulse shorter than 2*2^N clocks SHALL produce no db_tick and no db_level change.
REQ-019 The two buttons SHALL be fully independent; simultaneous presses SHALL yield db_tick pulses in the same cycle when the inputs are synchronized identically.
REQ-020 A button held continuously SHALL produce exactly one db_tick (no auto-repeat).

Reset
REQ-021 Asserting reset_amisha SHALL immediately force synchronizers to 0, the counter to 0, both FSMs to ZERO, db_level to 2'b00, and db_tick to 2'b00.
REQ-022 Reset mid-wait or mid-ONE SHALL discard progress; a button held through reset release SHALL be re-debounced from ZERO and yield one db_tick.
REQ-023 Reset deassertion SHALL be used as-is; no internal reset synchronizer.

Structure
REQ-024 A shared package SHALL hold the 3-bit state encoding constants (ZERO=0, WAIT1_1..3=1..3, ONE=4, WAIT0_1..3=5..7) and default N.
REQ-025 Sub-module debounce_fsm_amisha (inputs: clk, reset, sw, m_tick; outputs: db_level, db_tick) SHALL be instantiated twice; the counter and synchronizers live in the top.
REQ-026 The block is clocked only by clk_amisha; no derived clocks or gated enables.

Verification (bench overrides N=2, tick every 4 clocks)
REQ-027 Reset, then btn=2'b01 held for 40 clocks -> exactly one db_tick[0] pulse, in the window 10..15 clocks after the input edge; db_level[0]=1 from then; bit 1 stays 0.
REQ-028 btn[0] high for 5 clocks, then low -> db_tick and db_level stay 0 throughout.
REQ-029 Debounced press, then btn[0] released and held low 40 clocks -> db_level[0] falls 10..15 clocks after release; no db_tick.
REQ-030 btn=2'b11 from the same edge -> db_tick=2'b11 in the same cycle; one pulse each.
REQ-031 btn[1] high; reset_amisha pulsed while FSM is in WAIT1_2 -> outputs 0 during reset; after release, exactly one db_tick[1] within 10..15 clocks.
REQ-032 Bounce pattern 1,0,1,1,0,1 (one clock each), then stable high -> single db_tick, timed from the last 0->1 transition.
